// File: rtl/halfband_interp.sv
// 2x polyphase allpass interpolator: each accepted sample yields a branch-0
// then a branch-1 output, computed with wrapping Q8.20 first-order allpass sections.
module halfband_interp #(
    parameter logic [27:0] B0 = 28'h0000000,
    parameter logic [27:0] B1 = 28'h0000000
) (
    input  logic       clk_var,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {IDLE, CALC, EMIT0, EMIT1} state_t;

    state_t      state;
    logic [27:0] x_cur;
    logic [27:0] x_old  [2];
    logic [27:0] y_reg  [2];
    logic [27:0] y_next [2];
    logic [7:0]  out_data_r;
    logic        out_valid_r;

    function automatic logic signed [55:0] sext56(input logic [27:0] v);
        return {{28{v[27]}}, v};
    endfunction

    // y = B*x + x_old - B*y_old; x_old is realigned to the Q16.40 product scale
    function automatic logic [27:0] branch_y(input logic [27:0] b, input logic [27:0] x,
                                             input logic [27:0] xo, input logic [27:0] yo);
        logic signed [55:0] acc;
        acc = sext56(b) * sext56(x) + (sext56(xo) <<< 20) - sext56(b) * sext56(yo);
        return acc[47:20];
    endfunction

    always_comb begin
        y_next[0] = branch_y(B0, x_cur, x_old[0], y_reg[0]);
        y_next[1] = branch_y(B1, x_cur, x_old[1], y_reg[1]);
    end

    assign in_ready  = (state == IDLE) && enable;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

    always_ff @(posedge clk_var) begin
        if (reset) begin
            state       <= IDLE;
            x_cur       <= '0;
            x_old       <= '{default: '0};
            y_reg       <= '{default: '0};
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_cur <= {in_data, 20'b0};
                        state <= CALC;
                    end
                end
                CALC: begin
                    for (int unsigned k = 0; k < 2; k++) begin
                        x_old[k] <= x_cur;
                        y_reg[k] <= y_next[k];
                    end
                    out_data_r  <= y_next[0][27:20];
                    out_valid_r <= 1'b1;
                    state       <= EMIT0;
                end
                EMIT0: begin
                    if (out_ready) begin
                        out_data_r <= y_reg[1][27:20];
                        state      <= EMIT1;
                    end
                end
                EMIT1: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_halfband_interp.sv
// Bench for halfband_interp: two instances (zero and half-gain branch-0 coefficient)
// share stimulus; a reference model feeds per-instance scoreboards.
module tb_halfband_interp;

    localparam logic [27:0] BA0 = 28'h0000000;
    localparam logic [27:0] BA1 = 28'h0000000;
    localparam logic [27:0] BB0 = 28'h0080000;
    localparam logic [27:0] BB1 = 28'h0000000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready_a, in_ready_b, out_valid_a, out_valid_b;
    logic [7:0] out_data_a, out_data_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]  qa[$], qb[$], la[$], lb[$];
    logic [27:0] mxo[2][2];
    logic [27:0] myo[2][2];
    logic [27:0] coef[2][2];

    always #5 clk = ~clk;

    halfband_interp #(.B0(BA0), .B1(BA1)) dut_a (
        .clk_var(clk), .reset(reset), .enable(enable), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready));

    halfband_interp #(.B0(BB0), .B1(BB1)) dut_b (
        .clk_var(clk), .reset(reset), .enable(enable), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] model_y(input logic [27:0] b, input logic [27:0] x,
                                            input logic [27:0] xo, input logic [27:0] yo);
        longint bl, xl, xol, yol, s;
        bl  = longint'($signed(b));
        xl  = longint'($signed(x));
        xol = longint'($signed(xo));
        yol = longint'($signed(yo));
        s   = bl * xl + xol * 64'sd1048576 - bl * yol;
        return 28'(s >>> 20);
    endfunction

    initial begin
        coef[0][0] = BA0; coef[0][1] = BA1;
        coef[1][0] = BB0; coef[1][1] = BB1;
    end

    // Scoreboard: push model outputs on accepted inputs, pop on output transfers
    always @(negedge clk) begin
        if (reset) begin
            qa.delete(); qb.delete(); la.delete(); lb.delete();
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < 2; k++) begin
                    mxo[i][k] = '0;
                    myo[i][k] = '0;
                end
        end else if (enable) begin
            if (in_valid && in_ready_a) begin
                logic [27:0] x, y;
                x = {in_data, 20'b0};
                for (int i = 0; i < 2; i++)
                    for (int k = 0; k < 2; k++) begin
                        y = model_y(coef[i][k], x, mxo[i][k], myo[i][k]);
                        mxo[i][k] = x;
                        myo[i][k] = y;
                        if (i == 0) qa.push_back(y[27:20]);
                        else        qb.push_back(y[27:20]);
                    end
            end
            if (out_valid_a && out_ready) begin
                if (qa.size() == 0) chk("sb_a_unexpected", 32'd1, 32'd0);
                else chk("sb_a", out_data_a, qa.pop_front());
                la.push_back(out_data_a);
            end
            if (out_valid_b && out_ready) begin
                if (qb.size() == 0) chk("sb_b_unexpected", 32'd1, 32'd0);
                else chk("sb_b", out_data_b, qb.pop_front());
                lb.push_back(out_data_b);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", in_ready_a, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (qa.size() != 0 || qb.size() != 0 || out_valid_a); i++)
            @(negedge clk);
        chk("drain", qa.size() + qb.size() + out_valid_a, 0);
    endtask

    task automatic chk_log(input string tag, input logic [7:0] got[$], input int n,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e[4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_len"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk(tag, got[i], e[i]);
    endtask

    initial begin
        logic [7:0] d0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid_a", out_valid_a, 0);
        chk("rst_valid_b", out_valid_b, 0);
        chk("rst_ready_a", in_ready_a, 1);
        chk("rst_ready_b", in_ready_b, 1);
        chk("rst_data_a", out_data_a, 0);
        chk("rst_data_b", out_data_b, 0);

        // Zero coefficients: output is the previous input; two-cycle latency
        send(8'd5);
        chk("lat_calc_valid", out_valid_a, 0);
        chk("lat_calc_ready", in_ready_a, 0);
        @(posedge clk); #1;
        chk("lat_emit_valid", out_valid_a, 1);
        send(8'd7);
        @(posedge clk); #1;
        chk("lat2_emit_valid", out_valid_a, 1);
        drain();
        chk_log("zero_coef", la, 4, 8'd0, 8'd0, 8'd5, 8'd5);

        // Half-gain branch 0
        do_reset();
        send(8'd64);
        send(8'd0);
        drain();
        chk_log("half_coef", lb, 4, 8'd32, 8'd0, 8'd48, 8'd64);

        // Negative input rounds toward negative infinity
        do_reset();
        send(8'hC0);
        drain();
        chk_log("neg_in", lb, 2, 8'hE0, 8'h00, 8'h00, 8'h00);

        // Downstream stall in EMIT0
        do_reset();
        out_ready = 1'b0;
        send(8'd9);
        @(posedge clk); #1;
        d0 = out_data_b;
        chk("stall_first_b", d0, 8'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", out_valid_b, 1);
            chk("stall_data", out_data_b, d0);
            chk("stall_ready", in_ready_b, 0);
        end
        out_ready = 1'b1;
        drain();
        chk_log("stall_b", lb, 2, 8'd4, 8'd0, 8'd0, 8'd0);

        // Freeze during CALC must not alter the output sequence
        do_reset();
        send(8'd64);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("frz_valid", out_valid_b, 0);
            chk("frz_ready", in_ready_b, 0);
        end
        enable = 1'b1;
        send(8'd0);
        drain();
        chk_log("frz_b", lb, 4, 8'd32, 8'd0, 8'd48, 8'd64);

        // Reset while in EMIT1 discards the pending sample
        do_reset();
        out_ready = 1'b0;
        send(8'd64);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("emit1_valid", out_valid_b, 1);
        chk("emit1_data", out_data_b, 8'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_valid", out_valid_a, 0);
        chk("mid_rst_ready", in_ready_a, 1);
        chk("mid_rst_data", out_data_b, 0);
        out_ready = 1'b1;
        send(8'd5);
        drain();
        chk_log("post_rst_a", la, 2, 8'd0, 8'd0, 8'd0, 8'd0);
        chk_log("post_rst_b", lb, 2, 8'd2, 8'd0, 8'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
